// File: rtl/grid_game_pkg.sv
// grid_game_pkg: shared encodings for grid_game_logic.
// Direction and entity codes, step FSM states, reverse-heading helper.
package grid_game_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [1:0] ENT_EMPTY = 2'b00;
    localparam logic [1:0] ENT_BODY  = 2'b01;
    localparam logic [1:0] ENT_FOOD  = 2'b10;
    localparam logic [1:0] ENT_WALL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_FOOD   = 3'd4,
        ST_DEAD   = 3'd5
    } state_e;

    // Opposite headings differ only in bit 1.
    function automatic logic [1:0] reverse_dir(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR, taps 16,14,13,11, seed 16'hACE1.
// Ports: clk_i, rst_ni (sync, active-low), en_i advance, lfsr_o state.
module lfsr16 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign lfsr_o = lfsr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lfsr_q <= 16'hACE1;
        end else if (en_i) begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/grid_game_logic.sv
// grid_game_logic: snake playfield with step FSM, body ring buffer,
// occupancy bitmap, LFSR food placement and a per-pixel entity renderer.
// Ports: sys_clk, sys_rst (sync, active-low), dir heading request,
//   VGA_X/VGA_Y current pixel, update_clk step pulse, cur_ent_code
//   entity at pixel (1-cycle latency), game_over (sticky), score.
// Macro GRID_GAME_WRAP_EN: head wraps at the edges, no wall cells.
module grid_game_logic
    import grid_game_pkg::*;
#(
    parameter int GRID_W          = 40,
    parameter int GRID_H          = 30,
    parameter int CELL_PX         = 16,
    parameter int MAX_LEN         = 64,
    parameter int FRAMES_PER_STEP = 8,
    parameter int INIT_LEN        = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] dir,
    input  logic [9:0] VGA_X,
    input  logic [9:0] VGA_Y,
    output logic       update_clk,
    output logic [1:0] cur_ent_code,
    output logic       game_over,
    output logic [7:0] score
);

    localparam int CELLS = GRID_W * GRID_H;
    localparam int IW    = $clog2(CELLS);
    localparam int PW    = $clog2(MAX_LEN);
    localparam int LW    = PW + 1;
    localparam int FW    = $clog2(FRAMES_PER_STEP + 1);

    localparam logic [9:0] XMAX = 10'(GRID_W - 1);
    localparam logic [9:0] YMAX = 10'(GRID_H - 1);
    localparam logic [9:0] GW10 = 10'(GRID_W);
    localparam logic [9:0] GH10 = 10'(GRID_H);

`ifdef GRID_GAME_WRAP_EN
    localparam logic HAS_WALLS = 1'b0;
`else
    localparam logic HAS_WALLS = 1'b1;
`endif

    function automatic logic [IW-1:0] cell_idx(input logic [9:0] x,
                                               input logic [9:0] y);
        return IW'(y) * IW'(GRID_W) + IW'(x);
    endfunction

    function automatic logic is_wall(input logic [9:0] x,
                                     input logic [9:0] y);
        return HAS_WALLS &&
               ((x == '0) || (x == XMAX) || (y == '0) || (y == YMAX));
    endfunction

    state_e          state_q, state_d;
    logic [1:0]      heading_q, applied_q;
    logic [FW-1:0]   frame_q;
    logic [9:0]      body_x_q [MAX_LEN];
    logic [9:0]      body_y_q [MAX_LEN];
    logic [PW-1:0]   ptr_q;
    logic [LW-1:0]   len_q;
    logic [CELLS-1:0] occ_q;
    logic [9:0]      food_x_q, food_y_q;
    logic [9:0]      nxt_x_q, nxt_y_q;
    logic            oob_q, eat_q, vac_q;
    logic [7:0]      score_q;
    logic [1:0]      ent_q, ent_d;

    logic            frame_start, frame_hit, launch;
    logic [9:0]      head_x, head_y, nx, ny;
    logic [PW-1:0]   tail_ptr, ptr_nxt;
    logic [9:0]      tail_x, tail_y;
    logic            eat, vacate, occ_hit, collide;
    logic [IW-1:0]   nxt_idx, tail_idx;
    logic [15:0]     lfsr;
    logic [31:0]     cand;
    logic [9:0]      cand_x, cand_y;
    logic [IW-1:0]   cand_idx;
    logic            cand_ok;
    logic [9:0]      pcx, pcy;

    lfsr16 u_lfsr (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst),
        .en_i   (state_q != ST_DEAD),
        .lfsr_o (lfsr)
    );

    assign frame_start = (VGA_X == '0) && (VGA_Y == '0);
    assign frame_hit   = frame_start &&
                         (frame_q == FW'(FRAMES_PER_STEP - 1));
    assign launch      = frame_hit && (state_q == ST_IDLE);

    assign head_x  = body_x_q[ptr_q];
    assign head_y  = body_y_q[ptr_q];
    assign ptr_nxt = ptr_q + PW'(1);

    // Edge wrap is harmless without the macro: a border cell is a wall
    // there, so the head never sits on one when this is evaluated.
    always_comb begin
        nx = head_x;
        ny = head_y;
        unique case (heading_q)
            DIR_UP:    ny = (head_y == '0)   ? YMAX : head_y - 10'd1;
            DIR_RIGHT: nx = (head_x == XMAX) ? '0   : head_x + 10'd1;
            DIR_DOWN:  ny = (head_y == YMAX) ? '0   : head_y + 10'd1;
            DIR_LEFT:  nx = (head_x == '0)   ? XMAX : head_x - 10'd1;
            default:   nx = head_x;
        endcase
    end

    assign tail_ptr = ptr_q - PW'(len_q - LW'(1));
    assign tail_x   = body_x_q[tail_ptr];
    assign tail_y   = body_y_q[tail_ptr];
    assign tail_idx = cell_idx(tail_x, tail_y);
    assign nxt_idx  = cell_idx(nxt_x_q, nxt_y_q);

    // The tail only frees its cell when the snake is not growing.
    assign eat     = (nxt_x_q == food_x_q) && (nxt_y_q == food_y_q);
    assign vacate  = !eat || (len_q == LW'(MAX_LEN));
    assign occ_hit = occ_q[nxt_idx] &&
                     !(vacate && (nxt_x_q == tail_x) && (nxt_y_q == tail_y));
    assign collide = oob_q || occ_hit;

    assign cand     = 32'(lfsr) % 32'(CELLS);
    assign cand_x   = 10'(cand % 32'(GRID_W));
    assign cand_y   = 10'(cand / 32'(GRID_W));
    assign cand_idx = IW'(cand);
    assign cand_ok  = !occ_q[cand_idx] && !is_wall(cand_x, cand_y);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (launch) state_d = ST_CALC;
            ST_CALC:   state_d = ST_CHECK;
            ST_CHECK:  state_d = collide ? ST_DEAD : ST_COMMIT;
            ST_COMMIT: state_d = eat_q ? ST_FOOD : ST_IDLE;
            ST_FOOD:   if (cand_ok) state_d = ST_IDLE;
            ST_DEAD:   state_d = ST_DEAD;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign pcx = VGA_X / 10'(CELL_PX);
    assign pcy = VGA_Y / 10'(CELL_PX);

    always_comb begin
        ent_d = ENT_EMPTY;
        if ((pcx < GW10) && (pcy < GH10)) begin
            if (is_wall(pcx, pcy)) begin
                ent_d = ENT_WALL;
            end else if (occ_q[cell_idx(pcx, pcy)]) begin
                ent_d = ENT_BODY;
            end else if ((pcx == food_x_q) && (pcy == food_y_q)) begin
                ent_d = ENT_FOOD;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q   <= ST_IDLE;
            heading_q <= DIR_RIGHT;
            applied_q <= DIR_RIGHT;
            frame_q   <= '0;
            ptr_q     <= PW'(INIT_LEN - 1);
            len_q     <= LW'(INIT_LEN);
            food_x_q  <= 10'(GRID_W / 4);
            food_y_q  <= 10'(GRID_H / 4);
            nxt_x_q   <= '0;
            nxt_y_q   <= '0;
            oob_q     <= 1'b0;
            eat_q     <= 1'b0;
            vac_q     <= 1'b0;
            score_q   <= '0;
            ent_q     <= ENT_EMPTY;
            occ_q     <= '0;
            // Slot INIT_LEN-1 is the head; lower slots extend left.
            for (int i = 0; i < MAX_LEN; i++) begin
                body_x_q[i] <= (i < INIT_LEN) ?
                               10'(GRID_W / 2 - INIT_LEN + 1 + i) : '0;
                body_y_q[i] <= 10'(GRID_H / 2);
            end
            for (int i = 0; i < INIT_LEN; i++) begin
                occ_q[cell_idx(10'(GRID_W / 2 - INIT_LEN + 1 + i),
                               10'(GRID_H / 2))] <= 1'b1;
            end
        end else begin
            state_q <= state_d;
            ent_q   <= ent_d;
            if (dir != reverse_dir(applied_q)) begin
                heading_q <= dir;
            end
            if (frame_start) begin
                frame_q <= frame_hit ? '0 : frame_q + FW'(1);
            end
            unique case (state_q)
                ST_CALC: begin
                    nxt_x_q   <= nx;
                    nxt_y_q   <= ny;
                    oob_q     <= is_wall(nx, ny);
                    applied_q <= heading_q;
                end
                ST_CHECK: begin
                    eat_q <= eat;
                    vac_q <= vacate;
                end
                ST_COMMIT: begin
                    ptr_q             <= ptr_nxt;
                    body_x_q[ptr_nxt] <= nxt_x_q;
                    body_y_q[ptr_nxt] <= nxt_y_q;
                    // Clear before set: the new head may land on the old tail.
                    if (vac_q) begin
                        occ_q[tail_idx] <= 1'b0;
                    end
                    occ_q[nxt_idx] <= 1'b1;
                    if (!vac_q) begin
                        len_q <= len_q + LW'(1);
                    end
                    if (eat_q && (score_q != 8'hFF)) begin
                        score_q <= score_q + 8'd1;
                    end
                end
                ST_FOOD: begin
                    if (cand_ok) begin
                        food_x_q <= cand_x;
                        food_y_q <= cand_y;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign update_clk   = (state_q == ST_COMMIT);
    assign game_over    = (state_q == ST_DEAD);
    assign score        = score_q;
    assign cur_ent_code = ent_q;

endmodule

// File: tb/tb_grid_game_logic.sv
// tb_grid_game_logic: directed and random-walk steps of grid_game_logic
// against a queue-based snake model, observed via pulses and pixel probes.
`timescale 1ns/1ps
module tb_grid_game_logic;

    localparam int W      = 40;
    localparam int H      = 30;
    localparam int PX     = 16;
    localparam int ML     = 64;
    localparam int FPS    = 8;
    localparam int IL     = 3;
    localparam int SETTLE = 40;

    typedef struct {
        int x;
        int y;
    } cell_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [1:0] dir     = 2'b01;
    logic [9:0] VGA_X   = 10'd5;
    logic [9:0] VGA_Y   = 10'd5;
    logic       update_clk;
    logic [1:0] cur_ent_code;
    logic       game_over;
    logic [7:0] score;

    always #5 sys_clk = ~sys_clk;

    grid_game_logic #(
        .GRID_W          (W),
        .GRID_H          (H),
        .CELL_PX         (PX),
        .MAX_LEN         (ML),
        .FRAMES_PER_STEP (FPS),
        .INIT_LEN        (IL)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .dir          (dir),
        .VGA_X        (VGA_X),
        .VGA_Y        (VGA_Y),
        .update_clk   (update_clk),
        .cur_ent_code (cur_ent_code),
        .game_over    (game_over),
        .score        (score)
    );

    int n_vec = 0;
    int n_bad = 0;
    int upd_total = 0;

    always @(negedge sys_clk) if (update_clk === 1'b1) upd_total++;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural model: snake[0] is the head.
    cell_t snake[$];
    int    hd_m, ap_m, fx_m, fy_m, score_m;
    bit    food_known, dead_m;

    task automatic model_reset();
        snake.delete();
        for (int i = 0; i < IL; i++) snake.push_back('{W / 2 - i, H / 2});
        hd_m = 1;
        ap_m = 1;
        fx_m = W / 4;
        fy_m = H / 4;
        food_known = 1'b1;
        score_m = 0;
        dead_m = 1'b0;
    endtask

    function automatic bit wall_m(input int x, input int y);
`ifdef GRID_GAME_WRAP_EN
        return 1'b0;
`else
        return (x < 1) || (x > W - 2) || (y < 1) || (y > H - 2);
`endif
    endfunction

    function automatic int exp_code(input int x, input int y);
        if (wall_m(x, y)) return 3;
        foreach (snake[i]) if (snake[i].x == x && snake[i].y == y) return 1;
        if (food_known && x == fx_m && y == fy_m) return 2;
        return 0;
    endfunction

    task automatic model_step(input int d, output int exp_upd);
        int nx, ny, last;
        bit eat, grow, hit;
        exp_upd = 0;
        if (dead_m) return;
        if (d != (ap_m + 2) % 4) hd_m = d;
        ap_m = hd_m;
        nx = snake[0].x + ((hd_m == 1) ? 1 : (hd_m == 3) ? -1 : 0);
        ny = snake[0].y + ((hd_m == 2) ? 1 : (hd_m == 0) ? -1 : 0);
`ifdef GRID_GAME_WRAP_EN
        nx = (nx + W) % W;
        ny = (ny + H) % H;
`endif
        eat  = food_known && nx == fx_m && ny == fy_m;
        grow = eat && snake.size() < ML;
        hit  = wall_m(nx, ny);
        last = snake.size() - 1;
        foreach (snake[i]) begin
            if (!(i == last && !grow) && snake[i].x == nx && snake[i].y == ny)
                hit = 1'b1;
        end
        if (hit) begin
            dead_m = 1'b1;
            return;
        end
        snake.push_front('{nx, ny});
        if (!grow) void'(snake.pop_back());
        if (eat) begin
            if (score_m < 255) score_m++;
            food_known = 1'b0;
        end
        exp_upd = 1;
    endtask

    task automatic probe(input int cx, input int cy, output int code);
        VGA_X = 10'(cx * PX + int'($urandom_range(1, PX - 1)));
        VGA_Y = 10'(cy * PX + int'($urandom_range(0, PX - 1)));
        @(posedge sys_clk);
        #1;
        code = int'(cur_ent_code);
    endtask

    task automatic check_cell(input string tag, input int cx, input int cy);
        int got;
        probe(cx, cy, got);
        chk(tag, got, exp_code(cx, cy));
    endtask

    // Full-grid compare; an unknown food cell is located and adopted.
    task automatic scan(input string tag);
        int bad, nf, ffx, ffy, got, e;
        bad = 0;
        nf = 0;
        ffx = -1;
        ffy = -1;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                probe(x, y, got);
                e = exp_code(x, y);
                if (!food_known && got == 2 && e == 0) begin
                    nf++;
                    ffx = x;
                    ffy = y;
                end else if (got != e) begin
                    bad++;
                end
            end
        end
        chk({tag, "_cells_bad"}, bad, 0);
        if (!food_known) begin
            chk({tag, "_food_count"}, nf, 1);
            if (nf == 1) begin
                fx_m = ffx;
                fy_m = ffy;
                food_known = 1'b1;
            end
        end
    endtask

    task automatic frame_pulse();
        VGA_X = '0;
        VGA_Y = '0;
        @(posedge sys_clk);
        #1;
        VGA_X = 10'd5;
        VGA_Y = 10'd5;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_step(input logic [1:0] d, output int pulses);
        int base;
        dir = d;
        base = upd_total;
        for (int f = 0; f < FPS; f++) frame_pulse();
        repeat (SETTLE) @(posedge sys_clk);
        #1;
        pulses = upd_total - base;
    endtask

    task automatic run_step(input int d, input string tag);
        cell_t old_tail;
        int pulses, exp_upd;
        old_tail = snake[snake.size() - 1];
        do_step(2'(d), pulses);
        model_step(d, exp_upd);
        chk({tag, "_upd"}, pulses, exp_upd);
        chk({tag, "_over"}, int'(game_over), int'(dead_m));
        chk({tag, "_score"}, int'(score), score_m);
        check_cell({tag, "_head"}, snake[0].x, snake[0].y);
        check_cell({tag, "_oldtail"}, old_tail.x, old_tail.y);
        if (!food_known) scan({tag, "_newfood"});
    endtask

    task automatic do_reset();
        sys_rst = 1'b0;
        VGA_X = 10'd5;
        VGA_Y = 10'd5;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pd, d, rx, ry, base;

        sys_rst = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_upd", int'(update_clk), 0);
        chk("rst_over", int'(game_over), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_ent", int'(cur_ent_code), 0);
        sys_rst = 1'b1;
        model_reset();
        scan("reset");

        run_step(1, "first");
        run_step(3, "reverse");

        for (int i = 0; i < 8; i++) run_step(0, "up");
        for (int i = 0; i < 12; i++) run_step(3, "left");
        chk("food_score", int'(score), 1);
        scan("ate");

        // Reset landing while the step FSM sits in CHECK.
        dir = 2'b01;
        base = upd_total;
        for (int f = 0; f < FPS - 1; f++) frame_pulse();
        VGA_X = '0;
        VGA_Y = '0;
        @(posedge sys_clk);
        #1;
        VGA_X = 10'd5;
        VGA_Y = 10'd5;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("midrst_upd", int'(update_clk), 0);
        chk("midrst_over", int'(game_over), 0);
        chk("midrst_score", int'(score), 0);
        chk("midrst_ent", int'(cur_ent_code), 0);
        chk("midrst_nopulse", upd_total - base, 0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        model_reset();
        run_step(1, "after_rst");

        for (int i = 0; i < 20; i++) run_step(1, "edge");
        scan("edge");

        do_reset();
        pd = 1;
        for (int i = 0; i < 150; i++) begin
            d = ($urandom_range(0, 9) < 7) ? pd : int'($urandom_range(0, 3));
            pd = d;
            run_step(d, "rand");
            for (int k = 0; k < 3; k++) begin
                rx = int'($urandom_range(0, W - 1));
                ry = int'($urandom_range(0, H - 1));
                check_cell("rand_cell", rx, ry);
            end
            if (dead_m) begin
                run_step(pd, "rand_frozen");
                do_reset();
                pd = 1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
